// File: rtl/issue_ctrl.sv
// ----------------------------------------------------------------------------
// issue_ctrl
//
// Issue stage of the Tomasulo core. Every cycle the head of the instruction
// queue is decoded into a functional-unit class, a free reservation station
// of that class is picked round-robin and the next reorder-buffer slot is
// allocated. The resulting fu / RB_index / inst broadcast is valid for exactly
// one cycle, after which fu returns to NULL_FU (all ones). The block also
// tracks reorder-buffer occupancy and pulses reset_bus on a flush.
//
// Handshake: inst_valid / inst_ready is a strict valid/ready pair. The head
// instruction is consumed on a rising clk edge where both are high.
// inst_ready is purely combinational from the current inputs and state, and it
// never depends on itself.
//
// Optional feature: define ISSUE_STATS_EN to add the saturating statistics
// counters stat_issued and stat_stall. These count issues and stalled RUN
// cycles. Reset clears them; a flush does not.
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   inst_valid  in   instruction queue head valid
//   inst_in     in   head instruction
//   inst_ready  out  head consumed at this edge (the issue condition)
//   busy_in     in   reservation-station busy flags (sampled at the edge)
//   rb_commit   in   reorder buffer retires its head entry
//   rb_flush    in   mispredict: discard everything in flight
//   fu          out  target station; NULL_FU when nothing is issued
//   RB_index    out  allocated reorder-buffer slot
//   inst        out  issued instruction
//   reset_bus   out  per-station reset, high for one cycle after a flush
//   rb_count    out  occupied reorder-buffer entries (0..RB_SIZE)
//   fsm_state   out  current FSM state (0 = RUN, 1 = FLUSH), for observation
//   stat_issued out  (ISSUE_STATS_EN only) saturating issue counter
//   stat_stall  out  (ISSUE_STATS_EN only) saturating stall counter
// ----------------------------------------------------------------------------
module issue_ctrl #(
    parameter int                      FU_NUM       = 4,
    parameter int                      FU_INDEX     = 3,
    parameter int                      RB_SIZE      = 8,
    parameter int                      RB_INDEX     = 3,
    parameter int                      WORD_SIZE    = 32,
    parameter int                      OPCODE_WIDTH = 4,
    parameter logic [2*FU_NUM-1:0]     FU_CLASS     = 8'b10_01_00_00,
    parameter logic [OPCODE_WIDTH-1:0] OP_BGE       = 4'd8,
    parameter logic [OPCODE_WIDTH-1:0] OP_LD        = 4'd10,
    parameter logic [OPCODE_WIDTH-1:0] OP_ST        = 4'd11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_valid,
    input  logic [WORD_SIZE-1:0] inst_in,
    output logic                 inst_ready,
    input  logic [FU_NUM-1:0]    busy_in,
    input  logic                 rb_commit,
    input  logic                 rb_flush,
    output logic [FU_INDEX-1:0]  fu,
    output logic [RB_INDEX-1:0]  RB_index,
    output logic [WORD_SIZE-1:0] inst,
    output logic [FU_NUM-1:0]    reset_bus,
    output logic [RB_INDEX:0]    rb_count,
    output logic                 fsm_state
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [FU_INDEX-1:0] NULL_FU = '1;
    localparam logic [RB_INDEX:0]   RB_FULL = (RB_INDEX + 1)'(RB_SIZE);

    localparam logic [1:0] CLASS_ALU = 2'd0;
    localparam logic [1:0] CLASS_BR  = 2'd1;
    localparam logic [1:0] CLASS_MEM = 2'd2;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                state;
    logic [RB_INDEX-1:0]   tail;
    logic [FU_INDEX-1:0]   rr_ptr;
    logic [FU_NUM-1:0]     pending;

    // Next-state values produced by the combinational process
    state_t                state_next;
    logic [FU_INDEX-1:0]   fu_next;
    logic [RB_INDEX-1:0]   rb_index_next;
    logic [WORD_SIZE-1:0]  inst_next;
    logic [FU_NUM-1:0]     reset_bus_next;
    logic [RB_INDEX:0]     count_next;
    logic [RB_INDEX-1:0]   tail_next;
    logic [FU_INDEX-1:0]   ptr_next;
    logic [FU_NUM-1:0]     pending_next;

    // ------------------------------------------------------------------
    // Decode: opcode -> functional-unit class
    // ------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [1:0]              op_class;

    assign opcode = inst_in[WORD_SIZE-1 -: OPCODE_WIDTH];

    always_comb begin
        op_class = CLASS_ALU;
        if (opcode == OP_BGE) begin
            op_class = CLASS_BR;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
            op_class = CLASS_MEM;
        end
    end

    // ------------------------------------------------------------------
    // Free station vector
    // A station issued at the previous edge is masked through 'pending'
    // because its own busy flag only shows up at the following edge.
    // ------------------------------------------------------------------
    logic [FU_NUM-1:0] class_match;
    logic [FU_NUM-1:0] free;

    always_comb begin
        class_match = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            class_match[i] = (FU_CLASS[2*i +: 2] == op_class);
        end
    end

    assign free = ~busy_in & ~pending & class_match;

    // ------------------------------------------------------------------
    // Round-robin pick: first free station at or after rr_ptr, wrapping.
    // Two candidates are tracked: the lowest free index at/after the
    // pointer (hi) and the lowest free index overall (lo, used on wrap).
    // The loop runs downwards so the last hit is the lowest index.
    // ------------------------------------------------------------------
    logic                hit_hi;
    logic                hit_lo;
    logic [FU_INDEX-1:0] pick_hi;
    logic [FU_INDEX-1:0] pick_lo;
    logic [FU_NUM-1:0]   oh_hi;
    logic [FU_NUM-1:0]   oh_lo;
    logic [FU_INDEX-1:0] chosen;
    logic [FU_NUM-1:0]   chosen_oh;

    always_comb begin
        hit_hi  = 1'b0;
        hit_lo  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        oh_hi   = '0;
        oh_lo   = '0;
        for (int i = FU_NUM - 1; i >= 0; i--) begin
            if (free[i]) begin
                hit_lo   = 1'b1;
                pick_lo  = FU_INDEX'(i);
                oh_lo    = '0;
                oh_lo[i] = 1'b1;
                if (i >= int'(rr_ptr)) begin
                    hit_hi   = 1'b1;
                    pick_hi  = FU_INDEX'(i);
                    oh_hi    = '0;
                    oh_hi[i] = 1'b1;
                end
            end
        end
        chosen    = hit_hi ? pick_hi : pick_lo;
        chosen_oh = hit_hi ? oh_hi : oh_lo;
    end

    // ------------------------------------------------------------------
    // Issue condition
    // A full reorder buffer still accepts an issue when an entry retires
    // in the same cycle.
    // ------------------------------------------------------------------
    logic rb_room;
    logic issue;
    logic commit_eff;

    assign rb_room    = (rb_count < RB_FULL) || rb_commit;
    assign issue      = (state == RUN) && inst_valid && (|free) && rb_room && !rb_flush;
    assign inst_ready = issue;

    // Commit on an empty reorder buffer is dropped.
    assign commit_eff = rb_commit && (rb_count != '0);

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        fu_next        = NULL_FU;
        rb_index_next  = RB_index;
        inst_next      = inst;
        reset_bus_next = '0;
        count_next     = rb_count;
        tail_next      = tail;
        ptr_next       = rr_ptr;
        pending_next   = '0;

        case (state)
            RUN: begin
                if (rb_flush) begin
                    // Flush wins over issue and commit.
                    state_next     = FLUSH;
                    reset_bus_next = '1;
                    count_next     = '0;
                    tail_next      = '0;
                end else begin
                    if (issue) begin
                        fu_next       = chosen;
                        rb_index_next = tail;
                        inst_next     = inst_in;
                        tail_next     = tail + RB_INDEX'(1);
                        pending_next  = chosen_oh;
                        if (int'(chosen) == FU_NUM - 1) begin
                            ptr_next = '0;
                        end else begin
                            ptr_next = chosen + FU_INDEX'(1);
                        end
                    end
                    if (issue && !commit_eff) begin
                        count_next = rb_count + (RB_INDEX + 1)'(1);
                    end else if (!issue && commit_eff) begin
                        count_next = rb_count - (RB_INDEX + 1)'(1);
                    end
                end
            end

            FLUSH: begin
                // One-cycle state; rb_flush is ignored here. The buffer is
                // empty, so commit_eff is always low and rb_count holds.
                state_next = RUN;
                if (commit_eff) begin
                    count_next = rb_count - (RB_INDEX + 1)'(1);
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            fu        <= NULL_FU;
            RB_index  <= '0;
            inst      <= '0;
            reset_bus <= '0;
            rb_count  <= '0;
            tail      <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
        end else begin
            state     <= state_next;
            fu        <= fu_next;
            RB_index  <= rb_index_next;
            inst      <= inst_next;
            reset_bus <= reset_bus_next;
            rb_count  <= count_next;
            tail      <= tail_next;
            rr_ptr    <= ptr_next;
            pending   <= pending_next;
        end
    end

`ifdef ISSUE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters (survive a flush)
    // ------------------------------------------------------------------
    logic stall;

    assign stall = inst_valid && !issue && (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (stall && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_issue_ctrl
//
// Self-checking bench for issue_ctrl. Two instances share clk and reset:
//   dut  - default station classes (ALU, ALU, branch, memory)
//   dut2 - only station 2 is ALU, used for the pending-mask scenario
// Every accepted instruction pushes {fu, RB_index, inst} onto a queue; a
// monitor on the falling edge pops and compares whenever fu is not NULL_FU.
// ----------------------------------------------------------------------------
module tb_issue_ctrl;

    localparam int W = 3 + 3 + 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut signals ----------------
    logic        inst_valid;
    logic [31:0] inst_in;
    logic        inst_ready;
    logic [3:0]  busy_in;
    logic        rb_commit;
    logic        rb_flush;
    logic [2:0]  fu;
    logic [2:0]  RB_index;
    logic [31:0] inst;
    logic [3:0]  reset_bus;
    logic [3:0]  rb_count;
    logic        fsm_state;

    // ---------------- dut2 signals ----------------
    logic        inst_valid2;
    logic [31:0] inst_in2;
    logic        inst_ready2;
    logic [3:0]  busy_in2;
    logic        rb_commit2;
    logic        rb_flush2;
    logic [2:0]  fu2;
    logic [2:0]  RB_index2;
    logic [31:0] inst2;
    logic [3:0]  reset_bus2;
    logic [3:0]  rb_count2;
    logic        fsm_state2;

    issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst_in    (inst_in),
        .inst_ready (inst_ready),
        .busy_in    (busy_in),
        .rb_commit  (rb_commit),
        .rb_flush   (rb_flush),
        .fu         (fu),
        .RB_index   (RB_index),
        .inst       (inst),
        .reset_bus  (reset_bus),
        .rb_count   (rb_count),
        .fsm_state  (fsm_state)
    );

    issue_ctrl #(
        .FU_CLASS (8'b10_00_01_10)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_valid2),
        .inst_in    (inst_in2),
        .inst_ready (inst_ready2),
        .busy_in    (busy_in2),
        .rb_commit  (rb_commit2),
        .rb_flush   (rb_flush2),
        .fu         (fu2),
        .RB_index   (RB_index2),
        .inst       (inst2),
        .reset_bus  (reset_bus2),
        .rb_count   (rb_count2),
        .fsm_state  (fsm_state2)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q2[$];
    logic [W-1:0] mon_e;
    logic [W-1:0] mon_e2;
    logic [2:0]   tail_m;
    logic [2:0]   tail_m2;
    logic         mon_en;
    int           n_checks;
    int           n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && fu !== 3'b111) begin
            check("issue_q_nonempty", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("issue_fu", fu, mon_e[37:35]);
                check("issue_rb_index", RB_index, mon_e[34:32]);
                check("issue_inst", inst, mon_e[31:0]);
            end
        end
        if (mon_en && !reset && fu2 !== 3'b111) begin
            check("issue2_q_nonempty", 64'(exp_q2.size() != 0), 1);
            if (exp_q2.size() != 0) begin
                mon_e2 = exp_q2.pop_front();
                check("issue2_fu", fu2, mon_e2[37:35]);
                check("issue2_rb_index", RB_index2, mon_e2[34:32]);
                check("issue2_inst", inst2, mon_e2[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] mk(input logic [3:0] op);
        logic [27:0] payload;
        payload = 28'($urandom);
        return {op, payload};
    endfunction

    function automatic logic [3:0] alu_op();
        return 4'($urandom_range(0, 7));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: presents one instruction, expects it accepted at
    // the next edge into station exp_fu, returns at posedge+1.
    task automatic drive_issue(input logic [3:0] op, input logic [2:0] exp_fu);
        logic [31:0] w;
        w = mk(op);
        inst_valid = 1'b1;
        inst_in    = w;
        #1;
        check("inst_ready", inst_ready, 1);
        exp_q.push_back({exp_fu, tail_m, w});
        tail_m = tail_m + 3'd1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset  = 1'b0;
        tail_m  = '0;
        tail_m2 = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        n_checks    = 0;
        n_fail      = 0;
        mon_en      = 1'b0;
        tail_m      = '0;
        tail_m2     = '0;
        reset       = 1'b1;
        inst_valid  = 1'b0;
        inst_in     = '0;
        busy_in     = '0;
        rb_commit   = 1'b0;
        rb_flush    = 1'b0;
        inst_valid2 = 1'b0;
        inst_in2    = '0;
        busy_in2    = '0;
        rb_commit2  = 1'b0;
        rb_flush2   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Reset values
        check("rst_fu", fu, 3'd7);
        check("rst_rb_index", RB_index, 0);
        check("rst_inst", inst, 0);
        check("rst_reset_bus", reset_bus, 0);
        check("rst_rb_count", rb_count, 0);
        check("rst_state", fsm_state, 0);
        check("rst_fu2", fu2, 3'd7);

        // Single issue
        drive_issue(alu_op(), 3'd0);
        inst_valid = 1'b0;
        check("t1_fu", fu, 0);
        check("t1_rb_index", RB_index, 0);
        check("t1_rb_count", rb_count, 1);
        tick();
        check("t1_fu_idle", fu, 3'd7);

        // Class decode and round-robin
        do_reset();
        tick();
        drive_issue(alu_op(), 3'd0);
        drive_issue(alu_op(), 3'd1);
        drive_issue(alu_op(), 3'd0);
        drive_issue(4'd8,     3'd2);
        drive_issue(4'd10,    3'd3);
        inst_valid = 1'b0;
        check("t2_rb_count", rb_count, 5);

        // Fill the reorder buffer
        drive_issue(alu_op(), 3'd0);
        drive_issue(alu_op(), 3'd1);
        drive_issue(4'd11,    3'd3);
        inst_valid = 1'b1;
        inst_in    = mk(alu_op());
        #1;
        check("t3_full_ready", inst_ready, 0);
        check("t3_full_count", rb_count, 8);
        tick();
        // Commit and issue in the same cycle: slot index wraps to 0
        rb_commit = 1'b1;
        drive_issue(alu_op(), 3'd0);
        rb_commit  = 1'b0;
        inst_valid = 1'b0;
        check("t3_wrap_rb_index", RB_index, 0);
        check("t3_wrap_count", rb_count, 8);
        rb_commit = 1'b1;
        repeat (3) tick();
        rb_commit = 1'b0;
        check("t3_after_commit", rb_count, 5);

        // Flush together with a valid instruction
        rb_flush   = 1'b1;
        inst_valid = 1'b1;
        inst_in    = mk(alu_op());
        #1;
        check("t4_ready_flush", inst_ready, 0);
        tick();
        check("t4_reset_bus", reset_bus, 4'hF);
        check("t4_count", rb_count, 0);
        check("t4_fu", fu, 3'd7);
        check("t4_state", fsm_state, 1);
        check("t4_ready_in_flush", inst_ready, 0);
        tick();
        check("t4_reset_bus_low", reset_bus, 0);
        check("t4_state_run", fsm_state, 0);
        check("t4_count_hold", rb_count, 0);
        rb_flush = 1'b0;
        tail_m   = '0;
        drive_issue(alu_op(), 3'd1);
        inst_valid = 1'b0;
        check("t4_next_rb_index", RB_index, 0);

        // Async reset between edges while an issue is on the bus
        drive_issue(alu_op(), 3'd0);
        inst_valid = 1'b0;
        check("t5_fu_before", fu, 0);
        drive_issue(alu_op(), 3'd1);
        inst_valid = 1'b0;
        check("t5_fu_one", fu, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_fu", fu, 3'd7);
        check("t5_async_count", rb_count, 0);
        check("t5_async_rb_index", RB_index, 0);
        reset   = 1'b0;
        tail_m  = '0;
        tail_m2 = '0;
        tick();

        // Commit on an empty reorder buffer is ignored
        rb_commit = 1'b1;
        tick();
        rb_commit = 1'b0;
        check("t5_empty_commit", rb_count, 0);

        // Pending mask on dut2 (station 2 is the only ALU station)
        w           = mk(alu_op());
        inst_valid2 = 1'b1;
        inst_in2    = w;
        #1;
        check("t6_first_ready", inst_ready2, 1);
        exp_q2.push_back({3'd2, tail_m2, w});
        tail_m2 = tail_m2 + 3'd1;
        tick();
        w        = mk(alu_op());
        inst_in2 = w;
        #1;
        check("t6_pending_stall", inst_ready2, 0);
        tick();
        busy_in2 = 4'b0100;
        #1;
        check("t6_busy_stall", inst_ready2, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_busy_hold", inst_ready2, 0);
        end
        #3;
        busy_in2 = 4'b0000;
        #1;
        check("t6_release_ready", inst_ready2, 1);
        exp_q2.push_back({3'd2, tail_m2, w});
        tail_m2 = tail_m2 + 3'd1;
        tick();
        inst_valid2 = 1'b0;
        check("t6_count", rb_count2, 2);

        tick();
        tick();
        check("q_drained", 64'(exp_q.size()), 0);
        check("q2_drained", 64'(exp_q2.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
